// File: rtl/pc_call_stack_if.sv
// Bus/control bundle between the control sequencer and pc_call_stack.
// Optional feature macro: PC_REL_EN adds the 'rel' strobe.
interface pc_call_stack_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    localparam int SPW = $clog2(DEPTH + 1);

    logic             clr_n;
    logic             lp;
    logic             cp;
    logic             ep;
    logic             call;
    logic             ret;
`ifdef PC_REL_EN
    logic             rel;
`endif
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic [WIDTH-1:0] dout_oe;
    logic [WIDTH-1:0] pc;
    logic [SPW-1:0]   sp;
    logic             full;
    logic             empty;
    logic             ovf;
    logic             unf;

    // Sequencer side: drives strobes and bus data, observes PC state.
    modport master (
        output clr_n, lp, cp, ep, call, ret,
`ifdef PC_REL_EN
        output rel,
`endif
        output din,
        input  dout, dout_oe, pc, sp, full, empty, ovf, unf
    );

    // Program-counter side.
    modport slave (
        input  clr_n, lp, cp, ep, call, ret,
`ifdef PC_REL_EN
        input  rel,
`endif
        input  din,
        output dout, dout_oe, pc, sp, full, empty, ovf, unf
    );
endinterface

// File: rtl/pc_call_stack.sv
// Parametrised program counter with load/count/bus drive and a hardware
// call/return stack. Optional feature macro: PC_REL_EN (relative jump, pc+sext(din)).
module pc_call_stack #(
    parameter int               WIDTH     = 4,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    pc_call_stack_if.slave          bus
);
    localparam int SPW = $clog2(DEPTH + 1);
    localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [SPW-1:0]   SP_ONE  = SPW'(1);
    localparam logic [SPW-1:0]   SP_FULL = SPW'(DEPTH);
    localparam logic [WIDTH-1:0] PC_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] r_pc;
    logic [SPW-1:0]   r_sp;
    logic             r_ovf;
    logic             r_unf;
    logic [WIDTH-1:0] r_stack [DEPTH];

    logic [WIDTH-1:0] w_pc_next;
    logic [SPW-1:0]   w_sp_next;
    logic             w_ovf_next;
    logic             w_unf_next;
    logic             w_push;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_pc_inc;
    logic [SPW-1:0]   w_sp_m1;
    logic [AW-1:0]    w_wr_idx;
    logic [AW-1:0]    w_rd_idx;

    assign w_full   = (r_sp == SP_FULL);
    assign w_empty  = (r_sp == '0);
    assign w_pc_inc = r_pc + PC_ONE;       // wraps modulo 2^WIDTH
    assign w_sp_m1  = r_sp - SP_ONE;
    // sp never reaches DEPTH on a push, and is >=1 on a pop, so truncation is safe
    assign w_wr_idx = r_sp[AW-1:0];
    assign w_rd_idx = w_sp_m1[AW-1:0];

    // Next-state selection following the fixed action priority; rejected call/ret stops here.
    always_comb begin
        w_pc_next  = r_pc;
        w_sp_next  = r_sp;
        w_ovf_next = r_ovf;
        w_unf_next = r_unf;
        w_push     = 1'b0;
        if (!bus.clr_n) begin
            w_pc_next  = RESET_VAL;
            w_sp_next  = '0;
            w_ovf_next = 1'b0;
            w_unf_next = 1'b0;
        end else if (bus.call && bus.ret) begin
            w_ovf_next = 1'b1;
            w_unf_next = 1'b1;
        end else if (bus.call) begin
            if (w_full) begin
                w_ovf_next = 1'b1;
            end else begin
                w_push    = 1'b1;
                w_sp_next = r_sp + SP_ONE;
                w_pc_next = bus.din;
            end
        end else if (bus.ret) begin
            if (w_empty) begin
                w_unf_next = 1'b1;
            end else begin
                w_sp_next = w_sp_m1;
                w_pc_next = r_stack[w_rd_idx];
            end
        end else if (bus.lp) begin
            w_pc_next = bus.din;
`ifdef PC_REL_EN
        end else if (bus.rel) begin
            // modular add of the raw bits equals adding the sign-extended offset
            w_pc_next = r_pc + bus.din;
`endif
        end else if (bus.cp) begin
            w_pc_next = w_pc_inc;
        end
    end

    // PC, stack pointer and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc  <= RESET_VAL;
            r_sp  <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_pc  <= w_pc_next;
            r_sp  <= w_sp_next;
            r_ovf <= w_ovf_next;
            r_unf <= w_unf_next;
        end
    end

    // Return-address storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (w_push && rst_n) begin
            r_stack[w_wr_idx] <= w_pc_inc;
        end
    end

    assign bus.dout    = bus.ep ? r_pc : '0;
    assign bus.dout_oe = {WIDTH{bus.ep}};
    assign bus.pc      = r_pc;
    assign bus.sp      = r_sp;
    assign bus.full    = w_full;
    assign bus.empty   = w_empty;
    assign bus.ovf     = r_ovf;
    assign bus.unf     = r_unf;
endmodule

// File: tb/tb_pc_call_stack.sv
// Directed self-checking bench for pc_call_stack (WIDTH=4, DEPTH=4).
// Relative-jump cases are compiled in when PC_REL_EN is defined.
module tb_pc_call_stack;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pc_call_stack_if #(.WIDTH(4), .DEPTH(4)) bus ();

    pc_call_stack #(.WIDTH(4), .DEPTH(4), .RESET_VAL(4'h0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.lp = 0; bus.cp = 0; bus.call = 0; bus.ret = 0; bus.clr_n = 1;
`ifdef PC_REL_EN
        bus.rel = 0;
`endif
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.ep = 0; bus.din = 4'h0;
        idle();
        step(); step();
        rst_n = 1'b1;

        // 1. reset in the middle of counting
        bus.cp = 1;
        step(); step(); step();
        chk("pre_rst_count", bus.pc, 3);
        #2 rst_n = 1'b0;
        #1 chk("async_rst_pc", bus.pc, 0);
        bus.cp = 0;
        step();
        rst_n = 1'b1;
        step();
        chk("rst_pc", bus.pc, 0);
        chk("rst_sp", bus.sp, 0);
        chk("rst_empty", bus.empty, 1);
        chk("rst_ovf", bus.ovf, 0);
        chk("rst_unf", bus.unf, 0);
        chk("rst_dout", bus.dout, 0);
        chk("rst_dout_oe", bus.dout_oe, 0);

        // 2. count through wrap
        bus.cp = 1;
        for (int i = 0; i < 15; i++) step();
        chk("count_15", bus.pc, 15);
        step();
        chk("count_wrap", bus.pc, 0);
        step();
        chk("count_17", bus.pc, 1);
        bus.cp = 0; bus.ep = 1;
        #1;
        chk("ep_dout", bus.dout, 1);
        chk("ep_dout_oe", bus.dout_oe, 4'hF);
        bus.ep = 0;

        // 3. single call/return
        bus.lp = 1; bus.din = 4'h3; step(); idle();
        chk("load_3", bus.pc, 3);
        bus.call = 1; bus.din = 4'h9; step(); idle();
        chk("call_pc", bus.pc, 9);
        chk("call_sp", bus.sp, 1);
        chk("call_empty", bus.empty, 0);
        bus.ret = 1; step(); idle();
        chk("ret_pc", bus.pc, 4);
        chk("ret_sp", bus.sp, 0);
        chk("ret_empty", bus.empty, 1);

        // 4. nested calls to full: pushes 5,2,3,4 from pc 4,1,2,3
        bus.call = 1;
        bus.din = 4'h1; step();
        bus.din = 4'h2; step();
        bus.din = 4'h3; step();
        bus.din = 4'h5; step();
        chk("nest_pc", bus.pc, 5);
        chk("nest_sp", bus.sp, 4);
        chk("nest_full", bus.full, 1);
        chk("nest_ovf0", bus.ovf, 0);
        bus.din = 4'h7; bus.lp = 1; step(); idle();
        chk("ovf_pc_held", bus.pc, 5);
        chk("ovf_sp_held", bus.sp, 4);
        chk("ovf_set", bus.ovf, 1);
        bus.ret = 1;
        step(); chk("pop1", bus.pc, 4);
        step(); chk("pop2", bus.pc, 3);
        step(); chk("pop3", bus.pc, 2);
        step(); chk("pop4", bus.pc, 5);
        chk("pop_sp", bus.sp, 0);

        // 5. underflow, clear, illegal call+ret
        bus.cp = 1; step(); idle();
        chk("unf_pc_held", bus.pc, 5);
        chk("unf_set", bus.unf, 1);
        chk("ovf_sticky", bus.ovf, 1);
        bus.clr_n = 0; bus.call = 1; bus.din = 4'hA; step(); idle();
        chk("clr_pc", bus.pc, 0);
        chk("clr_sp", bus.sp, 0);
        chk("clr_unf", bus.unf, 0);
        chk("clr_ovf", bus.ovf, 0);
        bus.cp = 1; step(); idle();
        bus.call = 1; bus.ret = 1; bus.din = 4'h8; bus.cp = 1; step(); idle();
        chk("both_pc", bus.pc, 1);
        chk("both_sp", bus.sp, 0);
        chk("both_ovf", bus.ovf, 1);
        chk("both_unf", bus.unf, 1);

        // return address wraps: call from 15 pushes 0
        bus.lp = 1; bus.din = 4'hF; step(); idle();
        bus.call = 1; bus.din = 4'h2; step(); idle();
        chk("wrap_call_pc", bus.pc, 2);
        bus.ret = 1; step(); idle();
        chk("wrap_ret_pc", bus.pc, 0);

        // bus shows pre-edge PC while loading
        bus.ep = 1; bus.lp = 1; bus.din = 4'h6;
        #1 chk("ep_lp_pre", bus.dout, 0);
        step(); idle();
        chk("ep_lp_post", bus.dout, 6);
        bus.ep = 0;

`ifdef PC_REL_EN
        // 6. relative jump
        bus.lp = 1; bus.din = 4'h2; step(); idle();
        bus.rel = 1; bus.din = 4'hE; step(); idle();
        chk("rel_back2", bus.pc, 0);
        bus.rel = 1; bus.din = 4'h5; bus.cp = 1; step(); idle();
        chk("rel_fwd5", bus.pc, 5);
        bus.rel = 1; bus.lp = 1; bus.din = 4'hE; step(); idle();
        chk("rel_lp_wins", bus.pc, 4'hE);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
